// File: rtl/idma_backend_arbiter_pkg.sv
// Shared types and helpers for the iDMA backend arbiter.
// Optional per-requester outstanding counters: IDMA_BACKEND_ARBITER_OUTSTANDING_CNT_EN.
package idma_backend_arbiter_pkg;

    typedef enum logic {
        ArbFree   = 1'b0,
        ArbLocked = 1'b1
    } arb_state_e;

    // Explicit wrap so non-power-of-two requester counts rotate correctly.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num_inp);
        return (idx + 1 >= num_inp) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/idma_backend_arbiter_if.sv
// Frontend/backend request and completion bundle around the arbiter.
// Busy counter signals exist only with IDMA_BACKEND_ARBITER_OUTSTANDING_CNT_EN.
interface idma_backend_arbiter_if #(
    parameter int unsigned NumInp         = 2,
`ifdef IDMA_BACKEND_ARBITER_OUTSTANDING_CNT_EN
    parameter int unsigned MaxOutstanding = 8,
`endif
    parameter type         burst_req_t    = logic
);
    burst_req_t [NumInp-1:0] burst_req_i;
    logic       [NumInp-1:0] valid_i;
    logic       [NumInp-1:0] ready_o;
    logic       [NumInp-1:0] trans_complete_o;
    burst_req_t              burst_req_o;
    logic                    valid_o;
    logic                    ready_i;
    logic                    trans_complete_i;
    logic                    idle_o;
`ifdef IDMA_BACKEND_ARBITER_OUTSTANDING_CNT_EN
    logic [NumInp-1:0][$clog2(MaxOutstanding):0] busy_cnt_o;
    logic [NumInp-1:0]                           busy_o;

    modport slave (
        input  burst_req_i, valid_i, ready_i, trans_complete_i,
        output ready_o, burst_req_o, valid_o, trans_complete_o, idle_o, busy_cnt_o, busy_o
    );
    modport master (
        output burst_req_i, valid_i, ready_i, trans_complete_i,
        input  ready_o, burst_req_o, valid_o, trans_complete_o, idle_o, busy_cnt_o, busy_o
    );
`else
    modport slave (
        input  burst_req_i, valid_i, ready_i, trans_complete_i,
        output ready_o, burst_req_o, valid_o, trans_complete_o, idle_o
    );
    modport master (
        output burst_req_i, valid_i, ready_i, trans_complete_i,
        input  ready_o, burst_req_o, valid_o, trans_complete_o, idle_o
    );
`endif
endinterface

// File: rtl/idma_arb_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each issued burst.
module idma_arb_tag_fifo #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [Width-1:0]       data_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] cnt_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rptr_q];
    assign cnt_o   = cnt_q;

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/idma_backend_arbiter.sv
// Round-robin arbiter sharing one iDMA backend among NumInp frontends, with completion routing.
// Optional busy counters: IDMA_BACKEND_ARBITER_OUTSTANDING_CNT_EN.
module idma_backend_arbiter
    import idma_backend_arbiter_pkg::*;
#(
    parameter int unsigned NumInp         = 2,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned IdxWidth       = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    idma_backend_arbiter_if.slave bus
);
    localparam int unsigned CntWidth = $clog2(MaxOutstanding) + 1;
    typedef logic [IdxWidth-1:0] idx_t;
    typedef logic [CntWidth-1:0] cnt_t;

    arb_state_e state_q, state_d;
    idx_t       rr_q, rr_d, lock_idx_q, lock_idx_d, grant, head;
    logic       fifo_full, fifo_empty, push, pop, hs;
    cnt_t       fifo_cnt;

    // First valid requester at or after the pointer, unless a grant is locked.
    always_comb begin : p_arb
        logic        found;
        int unsigned cand;
        found = 1'b0;
        cand  = 0;
        grant = rr_q;
        if (state_q == ArbLocked) begin
            grant = lock_idx_q;
        end else begin
            for (int unsigned k = 0; k < NumInp; k++) begin
                cand = 32'(rr_q) + k;
                if (cand >= NumInp) cand = cand - NumInp;
                if (!found && bus.valid_i[idx_t'(cand)]) begin
                    found = 1'b1;
                    grant = idx_t'(cand);
                end
            end
        end
    end

    always_comb begin : p_out
        bus.burst_req_o      = bus.burst_req_i[grant];
        bus.valid_o          = bus.valid_i[grant] && !fifo_full;
        bus.ready_o          = '0;
        bus.ready_o[grant]   = bus.ready_i && !fifo_full;
        bus.trans_complete_o = '0;
        if (pop) bus.trans_complete_o[head] = 1'b1;
    end

    assign hs         = bus.valid_o && bus.ready_i;
    assign push       = hs;
    assign pop        = bus.trans_complete_i && !fifo_empty;
    assign bus.idle_o = fifo_empty && !(|bus.valid_i);

    always_comb begin : p_fsm
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_d       = rr_q;
        case (state_q)
            ArbFree: begin
                if (bus.valid_o && !bus.ready_i) begin
                    state_d    = ArbLocked;
                    lock_idx_d = grant;
                end
            end
            ArbLocked: begin
                if (hs) state_d = ArbFree;
            end
            default: state_d = ArbFree;
        endcase
        if (hs) rr_d = idx_t'(rr_next(32'(grant), NumInp));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ArbFree;
            rr_q       <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    idma_arb_tag_fifo #(
        .Width (IdxWidth),
        .Depth (MaxOutstanding)
    ) i_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (grant),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .cnt_o   (fifo_cnt)
    );

`ifdef IDMA_BACKEND_ARBITER_OUTSTANDING_CNT_EN
    for (genvar i = 0; i < NumInp; i++) begin : g_busy
        cnt_t busy_q;
        logic inc, dec;
        assign inc = bus.ready_o[i] && bus.valid_o;
        assign dec = bus.trans_complete_o[i];
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)         busy_q <= '0;
            else if (inc && !dec) busy_q <= busy_q + 1'b1;
            else if (dec && !inc) busy_q <= busy_q - 1'b1;
        end
        assign bus.busy_cnt_o[i] = busy_q;
        assign bus.busy_o[i]     = |busy_q;
    end
`endif

    // A completion with nothing outstanding is dropped; flag it in simulation.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(bus.trans_complete_i && fifo_cnt == '0))
                else $warning("trans_complete_i with no outstanding burst ignored");
        end
    end

endmodule

// File: tb/tb_idma_backend_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts outputs, a monitor compares them.
`timescale 1ns/1ps
module tb_idma_backend_arbiter;
    localparam int N = 3;
    localparam int M = 4;
    typedef logic [7:0] req_t;

    typedef struct {
        logic             valid;
        req_t             req;
        logic [N-1:0]     ready;
        logic [N-1:0]     tc;
        logic             idle;
        logic [N-1:0][7:0] busy;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic active = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    idma_backend_arbiter_if #(
        .NumInp         (N),
`ifdef IDMA_BACKEND_ARBITER_OUTSTANDING_CNT_EN
        .MaxOutstanding (M),
`endif
        .burst_req_t    (req_t)
    ) bus ();

    idma_backend_arbiter #(
        .NumInp         (N),
        .MaxOutstanding (M)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Reference model: outstanding bursts as a plain queue of owner indices.
    int   m_rr = 0;
    int   m_lock = -1;
    int   m_tags[$];
    exp_t exp_q[$];

    always @(negedge clk) begin
        exp_t         e;
        int           g;
        bit           full;
        logic [N-1:0] one;
        one = 1;
        if (!rst_n) begin
            m_rr = 0;
            m_lock = -1;
            m_tags.delete();
        end
        full = (m_tags.size() == M);
        g = m_rr;
        if (m_lock >= 0) g = m_lock;
        else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (bus.valid_i[c]) begin
                    g = c;
                    break;
                end
            end
        end
        e.valid = bus.valid_i[g] && !full;
        e.req   = bus.burst_req_i[g];
        e.ready = (bus.ready_i && !full) ? (one << g) : '0;
        e.tc    = (bus.trans_complete_i && m_tags.size() > 0) ? (one << m_tags[0]) : '0;
        e.idle  = (m_tags.size() == 0) && (bus.valid_i == '0);
        for (int i = 0; i < N; i++) begin
            e.busy[i] = '0;
            foreach (m_tags[j]) if (m_tags[j] == i) e.busy[i] = e.busy[i] + 8'd1;
        end
        if (active) exp_q.push_back(e);
        if (rst_n) begin
            if (e.tc != '0) void'(m_tags.pop_front());
            if (e.valid && bus.ready_i) begin
                m_tags.push_back(g);
                m_lock = -1;
                m_rr = (g + 1) % N;
            end else if (e.valid) begin
                m_lock = g;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (active) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("valid_o", 32'(bus.valid_o), 32'(e.valid));
                chk("ready_o", 32'(bus.ready_o), 32'(e.ready));
                chk("trans_complete_o", 32'(bus.trans_complete_o), 32'(e.tc));
                chk("idle_o", 32'(bus.idle_o), 32'(e.idle));
                if (e.valid) chk("burst_req_o", 32'(bus.burst_req_o), 32'(e.req));
`ifdef IDMA_BACKEND_ARBITER_OUTSTANDING_CNT_EN
                for (int i = 0; i < N; i++) begin
                    chk("busy_cnt_o", 32'(bus.busy_cnt_o[i]), 32'(e.busy[i]));
                    chk("busy_o", 32'(bus.busy_o[i]), 32'(e.busy[i] != 0));
                end
`endif
            end
        end
    end

    // Idle requesters get a fresh payload; active ones hold theirs.
    task automatic cyc(input logic [N-1:0] v, input logic r, input logic tc);
        @(posedge clk);
        #1;
        bus.valid_i = v;
        bus.ready_i = r;
        bus.trans_complete_i = tc;
        for (int i = 0; i < N; i++) if (!v[i]) bus.burst_req_i[i] = req_t'($urandom);
    endtask

    task automatic rep(input int n, input logic [N-1:0] v, input logic r, input logic tc);
        for (int i = 0; i < n; i++) cyc(v, r, tc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid_i = '0;
        bus.ready_i = 1'b0;
        bus.trans_complete_i = 1'b0;
        for (int i = 0; i < N; i++) bus.burst_req_i[i] = req_t'($urandom);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fairness: grants 0,1,2 back to back, then drain in order.
        rep(3, 3'b111, 1'b1, 1'b0);
        cyc(3'b000, 1'b0, 1'b0);
        rep(3, 3'b000, 1'b0, 1'b1);

        // Lock: requester 1 stalled, requester 0 joins, 1 still wins.
        rep(4, 3'b010, 1'b0, 1'b0);
        rep(2, 3'b011, 1'b0, 1'b0);
        cyc(3'b011, 1'b1, 1'b0);
        cyc(3'b001, 1'b1, 1'b0);
        cyc(3'b000, 1'b0, 1'b0);

        // Full: fill to MaxOutstanding, completion while full, then resume.
        rep(3, 3'b001, 1'b1, 1'b0);
        cyc(3'b001, 1'b1, 1'b1);
        rep(2, 3'b001, 1'b1, 1'b0);
        cyc(3'b000, 1'b0, 1'b0);
        rep(5, 3'b000, 1'b0, 1'b1);

        // Routing: issue from 2,0,2 then complete all three.
        cyc(3'b100, 1'b1, 1'b0);
        cyc(3'b001, 1'b1, 1'b0);
        cyc(3'b100, 1'b1, 1'b0);
        cyc(3'b000, 1'b0, 1'b0);
        rep(3, 3'b000, 1'b0, 1'b1);

        // Simultaneous push and pop.
        cyc(3'b001, 1'b1, 1'b0);
        cyc(3'b010, 1'b1, 1'b1);
        cyc(3'b000, 1'b0, 1'b1);
        cyc(3'b000, 1'b0, 1'b0);

        // Reset with outstanding bursts, then a stray completion.
        rep(3, 3'b111, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.valid_i = '0;
        bus.ready_i = 1'b0;
        bus.trans_complete_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(3'b000, 1'b0, 1'b1);
        cyc(3'b000, 1'b0, 1'b0);

        // Random traffic.
        for (int t = 0; t < 400; t++) begin
            cyc(N'($urandom), ($urandom % 4) != 0, ($urandom % 3) == 0);
        end
        cyc(3'b000, 1'b0, 1'b0);

        @(negedge clk);
        #2;
        active = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
